// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2315 scan sequencer: FSM encoding and ADC interface timing constants.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SETTLE,
        CONV,
        EMIT
    } scan_state_t;

    localparam int ADC_FRAME_CYC = 18;
    localparam int DUMMY_EDGES   = 1;
    localparam int SAMPLE_W_DEF  = 12;

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// ADC handshake and result stream shared by the scan sequencer (master) and its neighbours (slave).
interface adc_scan_ctrl_if import adc_pkg::*; #(
    parameter int CH_W     = 3,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) ();

    logic                adc_start;
    logic                adc_en;
    logic [15:0]         adc_data;
    logic                res_valid;
    logic [CH_W-1:0]     res_ch;
    logic [SAMPLE_W-1:0] res_data;
    logic                frame_done;

    modport master (
        output adc_start, res_valid, res_ch, res_data, frame_done,
        input  adc_en, adc_data
    );

    modport slave (
        input  adc_start, res_valid, res_ch, res_data, frame_done,
        output adc_en, adc_data
    );

endinterface

// File: rtl/adc_scan_ctrl_prio_next_ch.sv
// Finds the lowest set mask bit strictly above cur; cur = -1 yields the lowest set bit overall.
module prio_next_ch #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic signed [CH_W:0] cur,
    output logic [CH_W-1:0]   next_ch,
    output logic              found
);

    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        // Scan downwards so the last hit is the lowest qualifying index
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                next_ch = CH_W'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Scans enabled mux channels, averages 2^AVG_LOG2 LTC2315 conversions each and streams one result per channel.
module adc_scan_ctrl import adc_pkg::*; #(
    parameter int NUM_CH     = 8,
    parameter int CH_W       = 3,
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE_CYC = 16
) (
    input  logic              clk_100,
    input  logic              reset,
    input  logic              scan_en,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [CH_W-1:0]   mux_sel,
    output logic              busy,
    adc_scan_ctrl_if.master   bus
);

    localparam int N_AVG = 1 << AVG_LOG2;
    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE_CYC) + 1;

    scan_state_t         state;
    logic [NUM_CH-1:0]   mask_q;
    logic [CH_W-1:0]     ch;
    logic [SET_W-1:0]    settle_cnt;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic                en_q;
    logic [1:0]          dummy_left;

    logic [SAMPLE_W-1:0] sample;
    logic [ACC_W-1:0]    acc_sum;
    logic                en_rise;
    logic [CH_W-1:0]     first_ch;
    logic                first_found;
    logic [CH_W-1:0]     next_ch;
    logic                next_found;
    logic signed [CH_W:0] cur_idx;
    logic                unused_adc_bits;

    assign sample          = bus.adc_data[SAMPLE_W-1:0];
    assign unused_adc_bits = ^bus.adc_data[15:SAMPLE_W];
    assign acc_sum         = acc + ACC_W'(sample);
    assign en_rise         = bus.adc_en & ~en_q;
    assign cur_idx         = {1'b0, ch};

    prio_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_first (
        .mask    (ch_mask),
        .cur     ('1),
        .next_ch (first_ch),
        .found   (first_found)
    );

    prio_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_next (
        .mask    (mask_q),
        .cur     (cur_idx),
        .next_ch (next_ch),
        .found   (next_found)
    );

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state          <= IDLE;
            mask_q         <= '0;
            ch             <= '0;
            settle_cnt     <= '0;
            acc            <= '0;
            cnt            <= '0;
            en_q           <= 1'b0;
            dummy_left     <= '0;
            mux_sel        <= '0;
            busy           <= 1'b0;
            bus.adc_start  <= 1'b0;
            bus.res_valid  <= 1'b0;
            bus.res_ch     <= '0;
            bus.res_data   <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            en_q           <= bus.adc_en;
            bus.res_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_en && first_found) begin
                        mask_q <= ch_mask;
                        ch     <= first_ch;
                        busy   <= 1'b1;
                        state  <= SEL;
                    end
                end
                SEL: begin
                    mux_sel    <= ch;
                    settle_cnt <= SET_W'(SETTLE_CYC - 1);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        bus.adc_start <= 1'b1;
                        dummy_left    <= 2'(DUMMY_EDGES);
                        state         <= CONV;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CONV: begin
                    // The interface raises en once at its count 0 before real data; skip that edge
                    if (en_rise) begin
                        if (dummy_left != '0) begin
                            dummy_left <= dummy_left - 1'b1;
                        end else begin
                            acc <= acc_sum;
                            cnt <= cnt + 1'b1;
                            if (cnt == CNT_W'(N_AVG - 1)) begin
                                bus.adc_start  <= 1'b0;
                                bus.res_valid  <= 1'b1;
                                bus.res_ch     <= ch;
                                bus.res_data   <= SAMPLE_W'(acc_sum >> AVG_LOG2);
                                bus.frame_done <= ~next_found;
                                state          <= EMIT;
                            end
                        end
                    end
                end
                EMIT: begin
                    acc <= '0;
                    cnt <= '0;
                    if (next_found) begin
                        ch    <= next_ch;
                        state <= SEL;
                    end else if (scan_en && first_found) begin
                        mask_q <= ch_mask;
                        ch     <= first_ch;
                        state  <= SEL;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl: an ADC responder feeds per-channel ramps, expected averages are queued per frame.
module tb_adc_scan_ctrl;
    import adc_pkg::*;

    localparam int NUM_CH     = 8;
    localparam int CH_W       = 3;
    localparam int SAMPLE_W   = 12;
    localparam int AVG_LOG2   = 2;
    localparam int SETTLE_CYC = 16;
    localparam int N_AVG      = 1 << AVG_LOG2;

    logic              clk_100 = 1'b0;
    logic              reset;
    logic              scan_en;
    logic [NUM_CH-1:0] ch_mask;
    logic [CH_W-1:0]   mux_sel;
    logic              busy;

    adc_scan_ctrl_if #(.CH_W(CH_W), .SAMPLE_W(SAMPLE_W)) bus ();

    adc_scan_ctrl #(
        .NUM_CH     (NUM_CH),
        .CH_W       (CH_W),
        .SAMPLE_W   (SAMPLE_W),
        .AVG_LOG2   (AVG_LOG2),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk_100 (clk_100),
        .reset   (reset),
        .scan_en (scan_en),
        .ch_mask (ch_mask),
        .mux_sel (mux_sel),
        .busy    (busy),
        .bus     (bus)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        int ch;
        int data;
        bit last;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   base[NUM_CH];
    int   step[NUM_CH];
    int   convCnt  = 0;
    int   pulseIdx = 0;

    // Conversion k of a channel (k=1..N) returns base+(k-1)*step; pulse 0 is the dummy edge
    function automatic logic [15:0] adcWord(int ch, int k);
        if (k < 1)
            return {4'($urandom), 12'hFFF};
        return {4'($urandom), 12'(base[ch] + (k - 1) * step[ch])};
    endfunction

    function automatic int expAvg(int ch);
        int s = 0;
        for (int k = 0; k < N_AVG; k++)
            s += (base[ch] + k * step[ch]) & 'hFFF;
        return s / N_AVG;
    endfunction

    // ADC interface model: en pulses every 18 cycles while start is high, first one one cycle after start
    always @(posedge clk_100) begin
        if (bus.adc_start !== 1'b1) begin
            convCnt  = 0;
            pulseIdx = 0;
            bus.adc_en   <= 1'b0;
            bus.adc_data <= 16'($urandom);
        end else begin
            if (convCnt == 0) begin
                bus.adc_en   <= 1'b1;
                bus.adc_data <= adcWord(int'(mux_sel), pulseIdx);
                pulseIdx++;
            end else begin
                bus.adc_en   <= 1'b0;
                bus.adc_data <= 16'($urandom);
            end
            convCnt = (convCnt == ADC_FRAME_CYC - 1) ? 0 : convCnt + 1;
        end
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every result pulse is compared against the head of the expected queue
    exp_t e;
    always @(negedge clk_100) begin
        if (reset === 1'b0) begin
            if (bus.res_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result actual ch=%0d data=%0h required no result",
                             bus.res_ch, bus.res_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("res_ch", 32'(bus.res_ch), 32'(e.ch));
                    checkOutput("res_data", 32'(bus.res_data), 32'(e.data));
                    checkOutput("frame_done", 32'(bus.frame_done), 32'(e.last));
                    checkOutput("mux_sel_at_emit", 32'(mux_sel), 32'(e.ch));
                    checkOutput("adc_start_low_at_emit", 32'(bus.adc_start), 32'd0);
                end
            end else if (bus.frame_done === 1'b1) begin
                checks++;
                errors++;
                $display("[TB] FAIL frame_done_without_result actual frame_done=1 required 0");
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic applyStimulus(logic [NUM_CH-1:0] m, logic en);
        ch_mask = m;
        scan_en = en;
    endtask

    task automatic pushFrame(logic [NUM_CH-1:0] m);
        int last = -1;
        for (int i = 0; i < NUM_CH; i++)
            if (m[i]) last = i;
        for (int i = 0; i < NUM_CH; i++)
            if (m[i]) expQ.push_back('{i, expAvg(i), i == last});
    endtask

    task automatic waitBusy(logic level, int budget, string name);
        int i = 0;
        while (busy !== level && i < budget) begin
            @(negedge clk_100);
            i++;
        end
        if (busy !== level) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual busy=%0b required %0b", name, busy, level);
        end
    endtask

    task automatic waitResult(int budget);
        int i = 0;
        do begin
            @(negedge clk_100);
            i++;
        end while (bus.res_valid !== 1'b1 && i < budget);
        if (bus.res_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout actual res_valid=0 required 1");
        end
    endtask

    task automatic runFrame(logic [NUM_CH-1:0] m);
        pushFrame(m);
        applyStimulus(m, 1'b1);
        waitBusy(1'b1, 10, "frame_start");
        scan_en = 1'b0;
        waitBusy(1'b0, 3000, "frame_end");
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_adc_start", 32'(bus.adc_start), 32'd0);
    endtask

    task automatic randomizeChannels(int maxStep);
        for (int i = 0; i < NUM_CH; i++) begin
            base[i] = $urandom_range(0, 4095);
            step[i] = $urandom_range(0, maxStep);
        end
    endtask

    initial begin
        logic sawActive;
        int   i;

        reset = 1'b1;
        applyStimulus('0, 1'b0);
        for (int c = 0; c < NUM_CH; c++) begin
            base[c] = 0;
            step[c] = 0;
        end
        tick(3);
        checkOutput("rst_adc_start", 32'(bus.adc_start), 32'd0);
        checkOutput("rst_mux_sel", 32'(mux_sel), 32'd0);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst_res_ch", 32'(bus.res_ch), 32'd0);
        checkOutput("rst_res_data", 32'(bus.res_data), 32'd0);
        checkOutput("rst_frame_done", 32'(bus.frame_done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(2);

        $display("[TB] single channel ramp 0x0A0..0x0AC");
        base[0] = 'h0A0;
        step[0] = 4;
        runFrame(8'h01);

        $display("[TB] three channels with constant ch*0x100");
        for (int c = 0; c < NUM_CH; c++) begin
            base[c] = c * 'h100;
            step[c] = 0;
        end
        runFrame(8'b1010_0100);

        $display("[TB] full scale");
        for (int c = 0; c < NUM_CH; c++) begin
            base[c] = 'hFFF;
            step[c] = 0;
        end
        runFrame(8'h81);

        $display("[TB] zero mask holds idle, then ch7 only");
        applyStimulus('0, 1'b1);
        sawActive = 1'b0;
        repeat (60) begin
            @(negedge clk_100);
            if (busy !== 1'b0 || bus.adc_start !== 1'b0) sawActive = 1'b1;
        end
        checkOutput("zero_mask_inactive", 32'(sawActive), 32'd0);
        randomizeChannels(200);
        runFrame(8'h80);

        $display("[TB] scan_en dropped during second channel");
        randomizeChannels(200);
        pushFrame(8'b0100_1001);
        applyStimulus(8'b0100_1001, 1'b1);
        waitResult(500);
        scan_en = 1'b0;
        waitBusy(1'b0, 3000, "drop_end");
        checkOutput("drop_idle_busy", 32'(busy), 32'd0);

        $display("[TB] back-to-back frames with mid-frame mask change");
        randomizeChannels(300);
        pushFrame(8'h06);
        pushFrame(8'h30);
        applyStimulus(8'h06, 1'b1);
        waitBusy(1'b1, 10, "b2b_start");
        waitResult(500);
        ch_mask = 8'h30;
        waitResult(500);
        waitResult(500);
        scan_en = 1'b0;
        waitBusy(1'b0, 3000, "b2b_end");

        $display("[TB] random frames");
        for (int f = 0; f < 4; f++) begin
            randomizeChannels(300);
            runFrame(NUM_CH'($urandom_range(1, 255)));
        end

        $display("[TB] reset during conversion");
        applyStimulus(8'h01, 1'b1);
        i = 0;
        while (bus.adc_start !== 1'b1 && i < 100) begin
            @(negedge clk_100);
            i++;
        end
        checkOutput("abort_reached_conv", 32'(bus.adc_start), 32'd1);
        tick(25);
        reset = 1'b1;
        applyStimulus('0, 1'b0);
        @(negedge clk_100);
        checkOutput("abort_adc_start", 32'(bus.adc_start), 32'd0);
        checkOutput("abort_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("abort_mux_sel", 32'(mux_sel), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(300);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
